// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
// Sequencer for an external multiply-accumulate datapath. It accepts a job
// length, clears the MAC, streams operand pairs into it, spends one cycle
// draining the registered multiply stage and one cycle capturing the
// accumulator, then presents the dot product on a valid/ready handshake.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, len             job request and number of operand pairs (IDLE only)
//   abort                  synchronous cancel of the current job
//   op_valid, op_ready     operand stream handshake
//   op_a, op_b             unsigned operand pair
//   mac_en, mac_clr        enable / clear to the MAC (clear has priority there)
//   mac_a, mac_b           operands to the MAC, forced to 0 when mac_en is low
//   mac_cout               accumulator value returned by the MAC
//   result_valid, result_ready, result   result handshake
//   busy                   high in every state except IDLE
//   done                   one-cycle pulse when the result is accepted

module mac_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    len,
    input  logic                    abort,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    output logic                    mac_en,
    output logic                    mac_clr,
    output logic [DATA_WIDTH-1:0]   mac_a,
    output logic [DATA_WIDTH-1:0]   mac_b,
    input  logic [3*DATA_WIDTH-1:0] mac_cout,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [3*DATA_WIDTH-1:0] result,
    output logic                    busy,
    output logic                    done
);

    localparam int ACC_WIDTH = 3 * DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        STREAM  = 3'd2,
        FLUSH   = 3'd3,
        CAPTURE = 3'd4,
        OUT     = 3'd5
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [LEN_WIDTH-1:0]   count;
    logic [ACC_WIDTH-1:0]   result_q;
    logic                   kill;
    logic                   handshake;

    // An abort only matters once a job is running; in IDLE it is ignored.
    assign kill      = abort && (state != IDLE);
    assign handshake = (state == STREAM) && op_valid && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = CLEAR;
                end
            end
            CLEAR: begin
                next_state = (count == '0) ? OUT : STREAM;
            end
            STREAM: begin
                // The pair that empties the counter is the last one.
                if (handshake && (count == LEN_WIDTH'(1))) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                next_state = CAPTURE;
            end
            CAPTURE: begin
                next_state = OUT;
            end
            OUT: begin
                if (result_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (kill) begin
            next_state = IDLE;
        end
    end

    // Remaining-pair counter and captured result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            result_q <= '0;
        end else if (kill) begin
            count <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                count <= len;
            end else if (handshake) begin
                count <= count - LEN_WIDTH'(1);
            end

            // Zeroing in CLEAR gives an empty job its result of 0.
            if (state == CLEAR) begin
                result_q <= '0;
            end else if (state == CAPTURE) begin
                result_q <= mac_cout;
            end
        end
    end

    always_comb begin
        busy         = (state != IDLE);
        op_ready     = 1'b0;
        mac_en       = 1'b0;
        mac_clr      = 1'b0;
        mac_a        = '0;
        mac_b        = '0;
        result_valid = 1'b0;
        done         = 1'b0;
        unique case (state)
            CLEAR: begin
                mac_clr = 1'b1;
            end
            STREAM: begin
                op_ready = 1'b1;
                mac_en   = op_valid;
                if (op_valid) begin
                    mac_a = op_a;
                    mac_b = op_b;
                end
            end
            FLUSH: begin
                // Zero operands push the last registered product into the accumulator.
                mac_en = 1'b1;
            end
            OUT: begin
                result_valid = 1'b1;
                done         = result_ready;
            end
            default: begin
            end
        endcase
        // Abort clears the MAC and masks every other side effect this cycle.
        if (kill) begin
            op_ready     = 1'b0;
            mac_en       = 1'b0;
            mac_a        = '0;
            mac_b        = '0;
            mac_clr      = 1'b1;
            result_valid = 1'b0;
            done         = 1'b0;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl
// Self-checking bench for mac_seq_ctrl. A small behavioural MAC with a
// registered multiply stage closes the loop around the controller. Jobs come
// from a table of directed vectors with hand-computed results and latencies;
// abort, reset-in-FLUSH and abort-in-IDLE are hand-written sequences.

module tb_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        abort;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        mac_en;
    logic        mac_clr;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic [23:0] mac_cout;
    logic        result_valid;
    logic        result_ready;
    logic [23:0] result;
    logic        busy;
    logic        done;

    int n_compared = 0;
    int n_failed   = 0;

    typedef struct {
        int              len;
        logic [4:0][7:0] a;
        logic [4:0][7:0] b;
        bit              toggle;
        int              ready_delay;
        bit              start_in_out;
        logic [23:0]     exp_res;
        int              exp_lat;
    } vec_t;

    vec_t vecs[5];

    mac_seq_ctrl #(
        .DATA_WIDTH (8),
        .LEN_WIDTH  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .len          (len),
        .abort        (abort),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .mac_en       (mac_en),
        .mac_clr      (mac_clr),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_cout     (mac_cout),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: product registered, accumulated one enabled cycle
    // later; clear wins over enable. Deliberately not reset by rst_n so
    // leftover state must be removed by the controller's CLEAR.
    logic [23:0] prod_q = '0;
    logic [23:0] acc_q  = '0;
    always_ff @(posedge clk) begin
        if (mac_clr) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else if (mac_en) begin
            prod_q <= 24'(mac_a) * 24'(mac_b);
            acc_q  <= acc_q + prod_q;
        end
    end
    assign mac_cout = acc_q;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Runs one complete job from start to result acceptance and checks it.
    task automatic apply_stimulus(input vec_t v, input string tag);
        int          pair_idx   = 0;
        int          lat        = -1;
        int          out_cycles = 0;
        int          dones      = 0;
        int          viol       = 0;
        int          clr_cnt    = 0;
        int          rdy_cnt    = 0;
        int          exp_rdy;
        logic [23:0] seen       = '0;
        bit          accepted   = 1'b0;

        @(negedge clk);
        start        = 1'b1;
        len          = 8'(v.len);
        op_valid     = 1'b0;
        op_a         = '0;
        op_b         = '0;
        result_ready = 1'b0;
        abort        = 1'b0;
        #1;
        check_output({tag, " idle_before_start"}, 64'(busy), 64'd0);

        for (int cyc = 1; cyc <= 100 && !accepted; cyc++) begin
            @(negedge clk);
            start        = 1'b0;
            result_ready = 1'b0;
            if (pair_idx < v.len) begin
                op_valid = v.toggle ? (cyc % 2 == 0) : 1'b1;
                op_a     = v.a[pair_idx];
                op_b     = v.b[pair_idx];
            end else begin
                op_valid = 1'b0;
                op_a     = '0;
                op_b     = '0;
            end
            #1;
            if (mac_clr) clr_cnt++;
            if (op_ready) rdy_cnt++;
            if (op_ready && (mac_en != op_valid)) viol++;
            if (!mac_en && ((mac_a != 0) || (mac_b != 0))) viol++;
            if (!op_ready && mac_en && ((mac_a != 0) || (mac_b != 0))) viol++;
            if (done) viol++;
            if (op_valid && op_ready) pair_idx++;
            if (result_valid) begin
                if (lat < 0) begin
                    lat  = cyc;
                    seen = result;
                end else if (result != seen) begin
                    viol++;
                end
                if (v.start_in_out) start = 1'b1;
                if (out_cycles >= v.ready_delay) begin
                    result_ready = 1'b1;
                    accepted     = 1'b1;
                end
                out_cycles++;
                #1;
                if (done) dones++;
            end
        end
        check_output({tag, " accepted_in_time"}, 64'(accepted), 64'd1);

        @(negedge clk);
        start        = 1'b0;
        result_ready = 1'b0;
        op_valid     = 1'b0;
        #1;
        check_output({tag, " idle_after_accept"}, 64'(busy), 64'd0);
        check_output({tag, " no_second_done"}, 64'(done), 64'd0);

        exp_rdy = v.toggle ? ((v.len == 0) ? 0 : 2 * v.len - 1) : v.len;
        check_output({tag, " result"}, 64'(seen), 64'(v.exp_res));
        if (v.exp_lat >= 0) begin
            check_output({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
        end
        check_output({tag, " done_pulses"}, 64'(dones), 64'd1);
        check_output({tag, " clr_cycles"}, 64'(clr_cnt), 64'd1);
        check_output({tag, " ready_cycles"}, 64'(rdy_cnt), 64'(exp_rdy));
        check_output({tag, " protocol_violations"}, 64'(viol), 64'd0);
    endtask

    initial begin
        vec_t job;

        // len=3, (2,3),(4,5),(1,7): 6+20+7 = 33, valid at cycle 3+4.
        vecs[0] = '{len: 3, a: {8'd0, 8'd0, 8'd1, 8'd4, 8'd2},
                    b: {8'd0, 8'd0, 8'd7, 8'd5, 8'd3}, toggle: 1'b0,
                    ready_delay: 0, start_in_out: 1'b0, exp_res: 24'd33, exp_lat: 7};
        // len=4, all (255,255), valid toggling: 4*65025 = 260100; STREAM 2..8.
        vecs[1] = '{len: 4, a: {5{8'd255}}, b: {5{8'd255}}, toggle: 1'b1,
                    ready_delay: 0, start_in_out: 1'b0, exp_res: 24'd260100, exp_lat: 11};
        // len=0: CLEAR then straight to OUT with 0.
        vecs[2] = '{len: 0, a: '0, b: '0, toggle: 1'b0,
                    ready_delay: 0, start_in_out: 1'b0, exp_res: 24'd0, exp_lat: 2};
        // len=5, 2+12+30+56+90 = 190; ready held low 5 cycles with start pulses.
        vecs[3] = '{len: 5, a: {8'd9, 8'd7, 8'd5, 8'd3, 8'd1},
                    b: {8'd10, 8'd8, 8'd6, 8'd4, 8'd2}, toggle: 1'b0,
                    ready_delay: 5, start_in_out: 1'b1, exp_res: 24'd190, exp_lat: 9};
        // len=2, (0,9),(16,16): 256.
        vecs[4] = '{len: 2, a: {8'd0, 8'd0, 8'd0, 8'd16, 8'd0},
                    b: {8'd0, 8'd0, 8'd0, 8'd16, 8'd9}, toggle: 1'b0,
                    ready_delay: 0, start_in_out: 1'b0, exp_res: 24'd256, exp_lat: 6};

        rst_n        = 1'b0;
        start        = 1'b0;
        len          = '0;
        abort        = 1'b0;
        op_valid     = 1'b0;
        op_a         = '0;
        op_b         = '0;
        result_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_output("reset busy", 64'(busy), 64'd0);
        check_output("reset done", 64'(done), 64'd0);
        check_output("reset result_valid", 64'(result_valid), 64'd0);
        check_output("reset op_ready", 64'(op_ready), 64'd0);
        check_output("reset mac_en", 64'(mac_en), 64'd0);
        check_output("reset mac_clr", 64'(mac_clr), 64'd0);
        check_output("reset result", 64'(result), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Abort while IDLE does nothing.
        @(negedge clk);
        abort = 1'b1;
        #1;
        check_output("idle_abort mac_clr", 64'(mac_clr), 64'd0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check_output("idle_abort busy", 64'(busy), 64'd0);

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort in STREAM after 2 of 5 pairs.
        @(negedge clk);
        start = 1'b1;
        len   = 8'd5;
        @(negedge clk);
        start = 1'b0;
        #1;
        check_output("abort_seq clear", 64'(mac_clr), 64'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            op_valid = 1'b1;
            op_a     = 8'd10 + 8'(k);
            op_b     = 8'd20;
            #1;
            check_output($sformatf("abort_seq stream%0d op_ready", k), 64'(op_ready), 64'd1);
        end
        @(negedge clk);
        abort = 1'b1;
        #1;
        check_output("abort_seq mac_clr", 64'(mac_clr), 64'd1);
        check_output("abort_seq done", 64'(done), 64'd0);
        check_output("abort_seq result_valid", 64'(result_valid), 64'd0);
        @(negedge clk);
        abort    = 1'b0;
        op_valid = 1'b0;
        #1;
        check_output("abort_seq idle", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        check_output("abort_seq stays_idle", 64'({busy, done, result_valid}), 64'd0);

        job = '{len: 1, a: {8'd0, 8'd0, 8'd0, 8'd0, 8'd3},
                b: {8'd0, 8'd0, 8'd0, 8'd0, 8'd3}, toggle: 1'b0,
                ready_delay: 0, start_in_out: 1'b0, exp_res: 24'd9, exp_lat: 5};
        apply_stimulus(job, "after_abort");

        // Reset asserted during FLUSH.
        @(negedge clk);
        start = 1'b1;
        len   = 8'd2;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            op_valid = 1'b1;
            op_a     = 8'd5 + 8'(k);
            op_b     = 8'd5 + 8'(k);
        end
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        check_output("rst_seq in_flush", 64'({mac_en, op_ready}), 64'b10);
        rst_n = 1'b0;
        #1;
        check_output("rst_seq outputs_zero",
                     64'({busy, mac_en, mac_clr, op_ready, result_valid, done}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        job = '{len: 2, a: {8'd0, 8'd0, 8'd0, 8'd1, 8'd1},
                b: {8'd0, 8'd0, 8'd0, 8'd1, 8'd1}, toggle: 1'b0,
                ready_delay: 0, start_in_out: 1'b0, exp_res: 24'd2, exp_lat: 6};
        apply_stimulus(job, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the operand width.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 8, giving the width of the vector-length field.
REQ-003 Port clk, input, 1: clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port start, input, 1: request a dot product; sampled only in IDLE.
REQ-006 Port len, input, LEN_WIDTH: number of operand pairs; latched when start is accepted.
REQ-007 Port abort, input, 1: synchronous cancel of the current job.
REQ-008 Port op_valid, input, 1, and port op_ready, output, 1: operand stream handshake.
REQ-009 Port op_a, input, DATA_WIDTH, and port op_b, input, DATA_WIDTH: operand pair, unsigned.
REQ-010 Ports mac_en, output, 1, and mac_clr, output, 1: enable and clear to the MAC datapath.
REQ-011 Ports mac_a, output, DATA_WIDTH, and mac_b, output, DATA_WIDTH: operands to the MAC.
REQ-012 Port mac_cout, input, 3*DATA_WIDTH: accumulator value from the MAC.
REQ-013 Ports result_valid, output, 1, result_ready, input, 1, and result, output, 3*DATA_WIDTH: result handshake.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port done, output, 1: one-cycle pulse when a result is accepted.

Function
REQ-016 The controller SHALL drive a MAC whose multiply stage is registered, so each product reaches the accumulator one enabled cycle after its operands; mac_clr SHALL take priority over mac_en in that MAC.
REQ-017 The FSM SHALL have the states IDLE, CLEAR, STREAM, FLUSH, CAPTURE and OUT.
REQ-018 IDLE with start=1 SHALL move to CLEAR and latch len into the remaining-pair counter.
REQ-019 CLEAR SHALL assert mac_clr=1 for exactly one cycle, then move to STREAM, or to OUT with result=0 if the latched len is 0.
REQ-020 In STREAM, op_ready SHALL be 1, and mac_en SHALL equal op_valid with mac_a=op_a and mac_b=op_b.
REQ-021 Each STREAM handshake (op_valid & op_ready) SHALL decrement the counter, and the handshake that takes the counter to 0 SHALL move the FSM to FLUSH.
REQ-022 While op_valid=0 in STREAM, mac_en SHALL be 0, the MAC SHALL hold its state, and the FSM SHALL remain in STREAM.
REQ-023 FLUSH SHALL last one cycle with mac_en=1 and mac_a=mac_b=0 to drain the last product, then move to CAPTURE.
REQ-024 CAPTURE SHALL last one cycle with mac_en=0, SHALL register mac_cout into result, and SHALL then move to OUT.
REQ-025 OUT SHALL hold result_valid=1 with result stable until result_ready=1, and at that point SHALL pulse done and return to IDLE.
REQ-026 op_ready SHALL be 0 outside STREAM, and mac_a/mac_b SHALL be 0 whenever mac_en=0.
REQ-027 With op_valid held at 1, result_valid SHALL first assert exactly len+4 cycles after the cycle in which start is accepted.
REQ-028 The result SHALL be the sum of op_a*op_b over the job, modulo 2^(3*DATA_WIDTH), with no saturation.
REQ-029 start SHALL be ignored outside IDLE; a start in the same cycle as result acceptance SHALL NOT be accepted, so a new job needs a start sampled in IDLE.
REQ-030 abort=1 in any non-IDLE state SHALL force the FSM to IDLE, assert mac_clr=1 that cycle, suppress done and result_valid, and take priority over every other transition.
REQ-031 abort=1 in IDLE SHALL have no effect.

Reset
REQ-032 On rst_n=0, the state SHALL be IDLE, the counter and result SHALL be 0, and busy, done, result_valid, op_ready, mac_en and mac_clr SHALL all be 0, regardless of clk.
REQ-033 When rst_n is asserted mid-job, the next job SHALL begin from CLEAR with no leftover accumulator contribution.

Verification
REQ-034 start with len=3 and pairs (2,3), (4,5), (1,7) with op_valid held high -> result=33, result_valid first high at cycle 7 after start, one done pulse.
REQ-035 len=4 with op_valid toggling 1,0,1,0 and pairs all (255,255) -> result=260100, mac_en=0 in every op_valid=0 cycle.
REQ-036 len=0 -> one mac_clr cycle, op_ready never high, result=0 delivered.
REQ-037 result_ready held at 0 for 5 cycles in OUT -> result_valid and result stable throughout; start pulses in that window ignored.
REQ-038 abort in STREAM after 2 of 5 pairs -> IDLE next cycle, mac_clr=1, no done; a following len=1 job with pair (3,3) -> result=9.
REQ-039 rst_n asserted during FLUSH -> all outputs 0 immediately; a following len=2 job with pairs (1,1) and (1,1) -> result=2.
